xdma_read_mux: RTL
==================

Name: xdma_read_mux

Overview:
- Read-side counterpart of the XDMA write demultiplexer: merges N_INP read-data streams into one output stream.
- Round-robin arbitration at burst granularity: once an input is granted, the grant is locked until its last beat is accepted. Beats from different inputs never interleave.
- One registered output stage decouples downstream timing. The source index travels with each beat.
- Sits between the per-endpoint read paths and the XDMA AXI read-data return.

Parameters:
- N_INP, 32'd2, number of input streams (>= 1).
- data_t, logic, beat payload type.
- LOG_N_INP, (N_INP > 1) ? $clog2(N_INP) : 1, derived; do not override.
- sel_t, logic [LOG_N_INP-1:0], derived index type; do not override.
- CNT_W, 32'd32, width of the burst statistics counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- inp_data_i  in  N_INP x data_t  per-input beat payload.
- inp_last_i  in  N_INP  per-input last-beat flag.
- inp_valid_i  in  N_INP  per-input valid.
- inp_ready_o  out  N_INP  per-input ready; at most one bit high per cycle.
- oup_data_o  out  data_t  registered payload.
- oup_last_o  out  1  registered last flag.
- oup_idx_o  out  sel_t  registered source index of the current beat.
- oup_valid_o  out  1  registered valid.
- oup_ready_i  in  1  downstream ready.
- burst_cnt_o  out  CNT_W  completed-burst count; present only with XDMA_READ_MUX_STATS_EN.

Behaviour:
- Reset (async assert, sync release): oup_valid_o=0, oup_data_o='0, oup_last_o=0, oup_idx_o=0, state=IDLE, rr_ptr=0, lock_idx=0.
- Output register:
  - accept = !oup_valid_o || oup_ready_i.
  - inp_ready_o[i] = grant[i] && accept (combinational path from oup_ready_i).
  - On an input handshake the register loads data, last and the granted index, and oup_valid_o=1.
  - Else, if oup_ready_i, oup_valid_o=0.
  - Latency 1 cycle; sustained throughput 1 beat/cycle.
- While oup_valid_o && !oup_ready_i, all outputs hold stable.
- FSM IDLE:
  - grant = the first asserted inp_valid_i, searching upward from rr_ptr with wrap at N_INP-1 -> 0. Non-power-of-2 N_INP wraps correctly. No valid input -> no grant.
  - The first beat may transfer in the granting cycle.
  - Handshake with last=1: stay IDLE, rr_ptr <= (idx+1) mod N_INP.
  - Handshake with last=0: go LOCKED, lock_idx <= idx.
  - Grant without handshake (accept=0): no state change; re-arbitrate next cycle.
- FSM LOCKED:
  - grant = lock_idx only; other inputs see ready=0 even if valid.
  - Handshake with last=1: go IDLE, rr_ptr <= (lock_idx+1) mod N_INP.
  - Locked input dropping valid: wait; the lock is kept.
- N_INP=1: arbitration is trivial, oup_idx_o is always 0, and lock has no effect on ordering.
- Protocol rule on inputs: valid must not deassert, and data/last must not change, until ready. Checked by assertion under simulation only.
- Reset mid-burst: the in-flight beat is dropped, the FSM returns to IDLE, no partial-burst recovery.

Optional Feature:
- Macro XDMA_READ_MUX_STATS_EN.
- Defined: a CNT_W counter increments on every input handshake with last=1 and wraps modulo 2^CNT_W. It resets to 0 and is driven on burst_cnt_o.
- Undefined: neither the port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Package xdma_read_mux_pkg: FSM state enum (IDLE, LOCKED) and the LOG_N_INP computation helper.
- Sub-module xdma_rr_arbiter: combinational; valid vector + rr_ptr -> one-hot grant + index; parameter N_INP.
- Top level: FSM, lock register, rr_ptr, output register, optional counter.

Test Plan:
- Input 0 sends a 4-beat burst (D0..D3), oup_ready_i=1 -> D0..D3 appear on consecutive cycles starting 1 cycle later; oup_idx_o=0; oup_last_o=1 only with D3.
- Inputs 0 and 1 both present 3-beat bursts in cycle 0 -> all 3 beats of input 0, then all 3 of input 1; inp_ready_o[1]=0 while input 0 is locked.
- N_INP=3, all inputs continuously offer single-beat bursts -> grant order 0,1,2,0,1,2 (wrap at 2 -> 0).
- oup_ready_i=0 for 5 cycles mid-burst -> output held stable, inp_ready_o all 0 while the register is full; after release no beat is lost or duplicated.
- rst_ni pulsed low after beat 2 of a 4-beat burst -> oup_valid_o=0 immediately; after release, input 0 alone is granted first (rr_ptr=0).
- With XDMA_READ_MUX_STATS_EN, CNT_W=2: 5 bursts complete -> burst_cnt_o=1 (wrapped).

Source files
------------

// File: rtl/xdma_read_mux_pkg.sv
// Shared types and helpers for the XDMA read-data multiplexer.
package xdma_read_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_e;

    // Index width for N inputs; never narrower than one bit.
    function automatic int unsigned calc_log_n(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xdma_rr_arbiter.sv
// Combinational round-robin pick: first valid input at or above i_ptr, wrapping at N_INP-1.
module xdma_rr_arbiter
    import xdma_read_mux_pkg::*;
#(
    parameter int unsigned N_INP     = 32'd2,
    parameter int unsigned LOG_N_INP = calc_log_n(N_INP)
) (
    input  logic [N_INP-1:0]     i_valid,
    input  logic [LOG_N_INP-1:0] i_ptr,
    output logic [N_INP-1:0]     o_grant,
    output logic [LOG_N_INP-1:0] o_idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        j       = 0;
        found   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        // Modulo walk keeps non-power-of-2 N_INP wrapping at N_INP-1.
        for (int unsigned k = 0; k < N_INP; k++) begin
            j = (int'(i_ptr) + k) % N_INP;
            if (!found && i_valid[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = LOG_N_INP'(j);
            end
        end
    end

endmodule

// File: rtl/xdma_read_mux.sv
// Burst-locked round-robin merge of N_INP read-data streams into one registered output.
// Optional completed-burst counter on burst_cnt_o when XDMA_READ_MUX_STATS_EN is defined.
module xdma_read_mux
    import xdma_read_mux_pkg::*;
#(
    parameter int unsigned N_INP     = 32'd2,
    parameter type         data_t    = logic,
    parameter int unsigned LOG_N_INP = calc_log_n(N_INP),
    parameter type         sel_t     = logic [LOG_N_INP-1:0],
    parameter int unsigned CNT_W     = 32'd32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
`ifdef XDMA_READ_MUX_STATS_EN
    output logic [CNT_W-1:0]        burst_cnt_o,
`endif
    input  data_t [N_INP-1:0]       inp_data_i,
    input  logic  [N_INP-1:0]       inp_last_i,
    input  logic  [N_INP-1:0]       inp_valid_i,
    output logic  [N_INP-1:0]       inp_ready_o,
    output data_t                   oup_data_o,
    output logic                    oup_last_o,
    output sel_t                    oup_idx_o,
    output logic                    oup_valid_o,
    input  logic                    oup_ready_i
);

    mux_state_e         r_state;
    sel_t               r_rr_ptr;
    sel_t               r_lock_idx;

    logic [N_INP-1:0]   w_arb_grant;
    sel_t               w_arb_idx;
    logic [N_INP-1:0]   w_grant;
    sel_t               w_idx;
    sel_t               w_next_ptr;
    logic               w_accept;
    logic               w_hs;
    logic               w_last;

    xdma_rr_arbiter #(
        .N_INP     (N_INP),
        .LOG_N_INP (LOG_N_INP)
    ) u_arb (
        .i_valid (inp_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    // While locked only the owning input may proceed, valid or not.
    always_comb begin
        w_grant = '0;
        w_idx   = w_arb_idx;
        if (r_state == LOCKED) begin
            w_grant[r_lock_idx] = 1'b1;
            w_idx               = r_lock_idx;
        end else begin
            w_grant = w_arb_grant;
        end
    end

    assign w_accept    = !oup_valid_o || oup_ready_i;
    assign inp_ready_o = w_grant & {N_INP{w_accept}};
    assign w_hs        = |(inp_ready_o & inp_valid_i);
    assign w_last      = inp_last_i[w_idx];
    assign w_next_ptr  = (w_idx == sel_t'(N_INP - 1)) ? '0 : w_idx + sel_t'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
        end else if (w_hs) begin
            if (w_last) begin
                r_state  <= IDLE;
                r_rr_ptr <= w_next_ptr;
            end else if (r_state == IDLE) begin
                r_state    <= LOCKED;
                r_lock_idx <= w_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oup_valid_o <= 1'b0;
            oup_data_o  <= '0;
            oup_last_o  <= 1'b0;
            oup_idx_o   <= '0;
        end else if (w_hs) begin
            oup_valid_o <= 1'b1;
            oup_data_o  <= inp_data_i[w_idx];
            oup_last_o  <= w_last;
            oup_idx_o   <= w_idx;
        end else if (oup_ready_i) begin
            oup_valid_o <= 1'b0;
        end
    end

`ifdef XDMA_READ_MUX_STATS_EN
    logic [CNT_W-1:0] r_burst_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_burst_cnt <= '0;
        else if (w_hs && w_last)
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end

    assign burst_cnt_o = r_burst_cnt;
`endif

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(inp_ready_o));

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_proto
        a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
            inp_valid_i[gi] && !inp_ready_o[gi] |=>
            inp_valid_i[gi] && $stable(inp_data_i[gi]) && $stable(inp_last_i[gi]));
    end
`endif

endmodule
